text_streamer: RTL and testbench
================================

TEXT_STREAMER -- requirements
Module: text_streamer

Interface
REQ-001 SHALL have parameter NUM_CHARS, default 12, meaning number of glyphs per text line.
REQ-002 SHALL have parameter X_LEN, default 9, meaning glyph width in pixels.
REQ-003 SHALL have parameter Y_LEN, default 8, meaning glyph height in rows; LINE_W = NUM_CHARS*X_LEN (108) and FRAME_BITS = LINE_W*Y_LEN (864) are derived.
REQ-004 SHALL have port clk, input, 1, the single clock; all logic on rising edge.
REQ-005 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-006 SHALL have port start, input, 1, request to capture and stream one bitmap frame.
REQ-007 SHALL have port characters, input, FRAME_BITS, row-major glyph bitmap from the text LUT; pixel (row r, col c) = characters[FRAME_BITS-1 - LINE_W*r - c].
REQ-008 SHALL have port pixel_ready, input, 1, downstream accepts the current pixel.
REQ-009 SHALL have port pixel_valid, output, 1, pixel/row/col are valid.
REQ-010 SHALL have port pixel, output, 1, current pixel value (1 = lit).
REQ-011 SHALL have port row, output, $clog2(Y_LEN) (3), current pixel row.
REQ-012 SHALL have port col, output, $clog2(LINE_W) (7), current pixel column.
REQ-013 SHALL have port line_end, output, 1, high with the pixel at col = LINE_W-1.
REQ-014 SHALL have port frame_end, output, 1, high with the pixel at row = Y_LEN-1, col = LINE_W-1.
REQ-015 SHALL have port busy, output, 1, high in STREAM state.
REQ-016 SHALL have port done, output, 1, one-cycle pulse after the last pixel is accepted.

Function
REQ-017 SHALL implement FSM states IDLE, STREAM, DONE.
REQ-018 IDLE: on start=1 SHALL copy characters into an internal FRAME_BITS shadow register, clear row/col to 0, go to STREAM next cycle.
REQ-019 characters SHALL be sampled only at the IDLE start edge; changes during STREAM SHALL not affect output.
REQ-020 STREAM: pixel_valid SHALL be 1 and pixel SHALL equal the shadow bit addressed by current row/col (combinational from registers, zero added latency).
REQ-021 A pixel SHALL be transferred on a cycle with pixel_valid=1 and pixel_ready=1; only then SHALL col/row advance.
REQ-022 With pixel_ready=0, pixel, row, col, line_end, frame_end SHALL hold stable.
REQ-023 On transfer with col < LINE_W-1: col+1; with col = LINE_W-1: col->0, row+1.
REQ-024 On transfer at frame_end: row, col->0, FSM -> DONE; pixel_valid low next cycle.
REQ-025 DONE: done=1 for exactly one cycle, pixel_valid=0, then unconditional return to IDLE.
REQ-026 start SHALL be ignored in STREAM and DONE (no restart, no recapture).
REQ-027 First valid pixel appears the cycle after start; with pixel_ready held 1 the frame takes exactly FRAME_BITS (864) cycles of pixel_valid, done at cycle start+865.
REQ-028 row and col SHALL never exceed Y_LEN-1 and LINE_W-1; no wrap beyond frame.
REQ-029 In IDLE and DONE pixel, line_end, frame_end SHALL be 0.

Reset
REQ-030 On rst=1, asynchronously: state=IDLE, shadow register=0, row=0, col=0, pixel_valid=0, pixel=0, line_end=0, frame_end=0, busy=0, done=0.
REQ-031 rst asserted mid-STREAM SHALL abort the frame immediately with no done pulse; after release the block waits in IDLE for a new start.
REQ-032 start coincident with rst release cycle SHALL be honoured only on the first clk edge with rst=0.

Verification
REQ-033 All-ones characters, start pulse, pixel_ready=1 -> 864 consecutive pixel=1, line_end at cols 107 (8 times), frame_end once, done pulse at cycle 865.
REQ-034 Single bit characters[863-108*3-20]=1, others 0 -> pixel=1 only at row=3, col=20.
REQ-035 pixel_ready toggled 1,0,0,1 pattern -> each pixel held while ready=0, no pixel skipped or duplicated, total transfers 864.
REQ-036 characters changed and start re-pulsed during STREAM -> output stream matches the originally captured bitmap, no restart.
REQ-037 rst asserted at row=5, col=40 -> all outputs 0 asynchronously, no done; subsequent start streams from row=0, col=0.
REQ-038 Glyph "A" (LUT code 0) in char slot 0, spaces elsewhere -> row 0 cols 0..8 = 001110000, cols 9..107 = 0.

Source files
------------

// File: rtl/text_streamer.sv
// Captures a glyph bitmap on start and streams it out one pixel per accepted
// handshake, row-major, with row/column coordinates and line/frame markers.
module text_streamer #(
  parameter int unsigned NUM_CHARS  = 12,
  parameter int unsigned X_LEN      = 9,
  parameter int unsigned Y_LEN      = 8,
  localparam int unsigned LINE_W     = NUM_CHARS * X_LEN,
  localparam int unsigned FRAME_BITS = LINE_W * Y_LEN,
  localparam int unsigned RowW       = (Y_LEN > 1) ? $clog2(Y_LEN) : 1,
  localparam int unsigned ColW       = (LINE_W > 1) ? $clog2(LINE_W) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [FRAME_BITS-1:0] characters,
  input  logic                  pixel_ready,
  output logic                  pixel_valid,
  output logic                  pixel,
  output logic [RowW-1:0]       row,
  output logic [ColW-1:0]       col,
  output logic                  line_end,
  output logic                  frame_end,
  output logic                  busy,
  output logic                  done
);

  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StStream = 2'd1;
  localparam logic [1:0] StDone   = 2'd2;

  localparam logic [RowW-1:0] RowMax = RowW'(Y_LEN - 1);
  localparam logic [ColW-1:0] ColMax = ColW'(LINE_W - 1);
  localparam logic [RowW-1:0] RowOne = RowW'(1);
  localparam logic [ColW-1:0] ColOne = ColW'(1);

  logic [1:0]            state_q, state_d;
  logic [FRAME_BITS-1:0] shadow_q, shadow_d;
  logic [RowW-1:0]       row_q, row_d;
  logic [ColW-1:0]       col_q, col_d;

  logic streaming;
  logic at_line_end;
  logic at_frame_end;
  logic xfer;

  assign streaming    = (state_q == StStream);
  assign at_line_end  = streaming && (col_q == ColMax);
  assign at_frame_end = at_line_end && (row_q == RowMax);
  assign xfer         = streaming && pixel_ready;

  // The shadow register shifts left on every transfer, so the current pixel
  // is always its MSB; this walks the bitmap in row-major order.
  always_comb begin
    state_d  = state_q;
    shadow_d = shadow_q;
    row_d    = row_q;
    col_d    = col_q;
    case (state_q)
      StIdle: begin
        if (start) begin
          shadow_d = characters;
          row_d    = '0;
          col_d    = '0;
          state_d  = StStream;
        end
      end
      StStream: begin
        if (xfer) begin
          shadow_d = {shadow_q[FRAME_BITS-2:0], 1'b0};
          if (at_frame_end) begin
            row_d   = '0;
            col_d   = '0;
            state_d = StDone;
          end else if (at_line_end) begin
            col_d = '0;
            row_d = row_q + RowOne;
          end else begin
            col_d = col_q + ColOne;
          end
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      shadow_q <= '0;
      row_q    <= '0;
      col_q    <= '0;
    end else begin
      state_q  <= state_d;
      shadow_q <= shadow_d;
      row_q    <= row_d;
      col_q    <= col_d;
    end
  end

  always_comb begin
    pixel_valid = streaming;
    busy        = streaming;
    pixel       = streaming && shadow_q[FRAME_BITS-1];
    row         = row_q;
    col         = col_q;
    line_end    = at_line_end;
    frame_end   = at_frame_end;
    done        = (state_q == StDone);
  end

endmodule

// File: tb/tb_text_streamer.sv
// Bench for text_streamer: table of frame scenarios checked against a
// pixel scoreboard, plus hand-written reset/abort sequences.
module tb_text_streamer;

  localparam int LW     = 108;
  localparam int YL     = 8;
  localparam int FB     = LW * YL;
  localparam int Budget = 4000;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [FB-1:0] characters = '0;
  logic          pixel_ready = 1'b0;
  logic          pixel_valid;
  logic          pixel;
  logic [2:0]    row;
  logic [6:0]    col;
  logic          line_end;
  logic          frame_end;
  logic          busy;
  logic          done;

  int checks   = 0;
  int failures = 0;

  logic [12:0] exp_q[$];

  text_streamer dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .characters (characters),
    .pixel_ready(pixel_ready),
    .pixel_valid(pixel_valid),
    .pixel      (pixel),
    .row        (row),
    .col        (col),
    .line_end   (line_end),
    .frame_end  (frame_end),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    string name;
    int    pat;    // 0 ones, 1 single bit, 2 glyph A, 3 random
    int    mode;   // 0 ready=1, 1 ready 1,0,0,1, 2 ready=1 + mid-frame disturbance
    int    exp_lit; // -1: not checked
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [FB-1:0] make_bitmap(input int pat);
    logic [FB-1:0] bm;
    logic [8:0]    glyph [8];
    bm = '0;
    glyph[0] = 9'b001110000;
    glyph[1] = 9'b010001000;
    glyph[2] = 9'b100000100;
    glyph[3] = 9'b100000100;
    glyph[4] = 9'b111111100;
    glyph[5] = 9'b100000100;
    glyph[6] = 9'b100000100;
    glyph[7] = 9'b000000000;
    case (pat)
      0: bm = '1;
      1: bm[FB-1 - LW*3 - 20] = 1'b1;
      2: begin
        for (int r = 0; r < YL; r++)
          for (int c = 0; c < 9; c++)
            bm[FB-1 - LW*r - c] = glyph[r][8-c];
      end
      default: begin
        for (int i = 0; i < FB; i++) bm[i] = 1'($urandom_range(0, 1));
      end
    endcase
    return bm;
  endfunction

  function automatic logic ready_for(input int mode, input int k);
    logic [3:0] pat;
    pat = 4'b1001;
    if (mode == 1) return pat[3 - (k % 4)];
    return 1'b1;
  endfunction

  task automatic run_frame(input string name, input int pat, input int mode, input int exp_lit,
                           input bit rel_rst);
    logic [FB-1:0] bm;
    logic [12:0]   cur, held, exp;
    bit            have_hold;
    int xfers, lit, lines, frames, dones, done_at;
    bm = make_bitmap(pat);
    xfers = 0; lit = 0; lines = 0; frames = 0; dones = 0; done_at = -1;
    have_hold = 0;
    held = '0;
    exp_q.delete();
    @(posedge clk); #1;
    characters  = bm;
    start       = 1'b1;
    pixel_ready = 1'b1;
    if (rel_rst) rst = 1'b0;
    for (int r = 0; r < YL; r++)
      for (int c = 0; c < LW; c++)
        exp_q.push_back({bm[FB-1 - LW*r - c], 3'(r), 7'(c), c == LW-1, (c == LW-1) && (r == YL-1)});
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 1; k <= Budget; k++) begin
      pixel_ready = ready_for(mode, k);
      if (mode == 2 && k == 100) begin
        characters = ~bm;
        start      = 1'b1;
      end
      if (mode == 2 && k == 101) start = 1'b0;
      @(negedge clk);
      cur = {pixel, row, col, line_end, frame_end};
      if (have_hold) begin
        check({name, "_hold"}, 64'(cur), 64'(held));
        have_hold = 0;
      end
      if (pixel_valid) begin
        if (pixel_ready) begin
          xfers++;
          if (pixel) lit++;
          if (line_end) lines++;
          if (frame_end) frames++;
          if (exp_q.size() == 0) begin
            check({name, "_extra_pixel"}, 64'(cur), 64'h1fff_0000);
          end else begin
            exp = exp_q.pop_front();
            check({name, "_pixel"}, 64'(cur), 64'(exp));
          end
        end else begin
          held      = cur;
          have_hold = 1;
        end
      end
      if (done) begin
        dones++;
        done_at = k;
        check({name, "_done_quiet"}, 64'({pixel_valid, pixel, line_end, frame_end, busy}), 64'd0);
      end
      if (done_at > 0 && k == done_at + 1) begin
        check({name, "_idle_after_done"}, 64'({done, pixel_valid, busy}), 64'd0);
        break;
      end
      @(posedge clk); #1;
    end
    check({name, "_done_seen"}, 64'(done_at > 0), 64'd1);
    check({name, "_transfers"}, 64'(xfers), 64'(FB));
    check({name, "_line_ends"}, 64'(lines), 64'(YL));
    check({name, "_frame_ends"}, 64'(frames), 64'd1);
    check({name, "_done_pulses"}, 64'(dones), 64'd1);
    if (exp_lit >= 0) check({name, "_lit"}, 64'(lit), 64'(exp_lit));
    if (mode != 1) check({name, "_done_cycle"}, 64'(done_at), 64'(FB + 1));
  endtask

  vec_t vecs [5];
  int   found;
  int   saw_done;

  initial begin
    vecs[0] = '{name: "ones",    pat: 0, mode: 0, exp_lit: FB};
    vecs[1] = '{name: "single",  pat: 1, mode: 0, exp_lit: 1};
    vecs[2] = '{name: "glyph_a", pat: 2, mode: 0, exp_lit: 20};
    vecs[3] = '{name: "stall",   pat: 3, mode: 1, exp_lit: -1};
    vecs[4] = '{name: "disturb", pat: 3, mode: 2, exp_lit: -1};

    #12;
    check("reset_outputs",
          64'({pixel_valid, pixel, row, col, line_end, frame_end, busy, done}), 64'd0);
    // start held across an edge while in reset must not capture
    start = 1'b1;
    @(posedge clk); #1;
    check("start_in_reset", 64'({pixel_valid, busy}), 64'd0);
    start = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;

    for (int i = 0; i < 5; i++) run_frame(vecs[i].name, vecs[i].pat, vecs[i].mode,
                                          vecs[i].exp_lit, 1'b0);

    // Abort mid-frame at row 5, col 40
    @(posedge clk); #1;
    characters  = '1;
    start       = 1'b1;
    pixel_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    found = 0;
    for (int k = 0; k < Budget; k++) begin
      @(negedge clk);
      if (pixel_valid && row == 3'd5 && col == 7'd40) begin
        found = 1;
        break;
      end
    end
    check("abort_reached_r5c40", 64'(found), 64'd1);
    #2 rst = 1'b1;
    #1;
    check("abort_async_outputs",
          64'({pixel_valid, pixel, row, col, line_end, frame_end, busy, done}), 64'd0);
    saw_done = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (done || pixel_valid) saw_done = 1;
    end
    check("abort_no_done", 64'(saw_done), 64'd0);
    // start coincident with reset release streams from row 0, col 0
    run_frame("after_abort", 1, 0, 1, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
